// File: rtl/prepro_frame_receiver_pkg.sv
// Definitions shared by the preprocessing transmitter and the frame receiver,
// so that both ends of the stream agree on how many words make up one frame.
package prepro_frame_receiver_pkg;

  localparam int NUM_OF_REG_DEF = 5;
  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } rxState_e;

  // Number of words the transmitter emits per frame for a given register depth.
  function automatic int totalInputNum(input int numOfReg, input int addrW);
    return (1 << addrW) - numOfReg + 1;
  endfunction

  localparam int TOTAL_INPUT_NUM = totalInputNum(NUM_OF_REG_DEF, ADDR_W_DEF);

endpackage

// File: rtl/prepro_frame_ram.sv
// Single-write, single-registered-read frame buffer. A read that collides
// with a write to the same address returns the previously stored word.
module prepro_frame_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdData_q;

  // Non-blocking write and read in the same block give read-old-on-collision.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/prepro_frame_receiver.sv
// Receives the preprocessing stream, checks the 0..TOTAL-1 address sequence,
// buffers one frame and hands it to the SNN input layer via ready/release.
module prepro_frame_receiver
  import prepro_frame_receiver_pkg::*;
#(
  parameter int num_of_reg = NUM_OF_REG_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              processed_dat_valid,
  input  logic [ADDR_W-1:0] processed_dat_addr,
  input  logic [DATA_W-1:0] processed_dat_in,
  input  logic              prepro_finished,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              buf_ready,
  input  logic              buf_release,
  output logic              frame_done,
  output logic [ADDR_W:0]   words_rcvd,
  output logic              seq_err,
  input  logic              err_clr
);

  localparam int              TOTAL   = totalInputNum(num_of_reg, ADDR_W);
  localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W+1)'(TOTAL);

  rxState_e          state_q;
  logic [ADDR_W:0]   wordsRcvd_q;
  logic              seqErr_q;
  logic              frameDone_q;
  logic              rdInRange_q;
  logic              acceptWord;
  logic [ADDR_W:0]   cntInc;
  logic [DATA_W-1:0] ramData;

  // Decide whether the word on the stream this cycle is written into the buffer.
  always_comb begin
    acceptWord = 1'b0;
    if (!rst && processed_dat_valid) begin
      case (state_q)
        EMPTY:   acceptWord = (processed_dat_addr == '0);
        FILL:    acceptWord = ({1'b0, processed_dat_addr} == wordsRcvd_q) &&
                              (wordsRcvd_q < TOTAL_W);
        READY:   acceptWord = buf_release && (processed_dat_addr == '0);
        default: acceptWord = 1'b0;
      endcase
    end
  end

  assign cntInc = wordsRcvd_q + {{ADDR_W{1'b0}}, acceptWord};

  // Control FSM. err_clr is applied first so any later error set in the same
  // cycle overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      wordsRcvd_q <= '0;
      seqErr_q    <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      if (err_clr) begin
        seqErr_q <= 1'b0;
      end
      case (state_q)
        EMPTY: begin
          if (processed_dat_valid && !acceptWord) begin
            seqErr_q <= 1'b1;
          end
          if (prepro_finished) begin
            seqErr_q    <= 1'b1;
            wordsRcvd_q <= '0;
          end else if (acceptWord) begin
            wordsRcvd_q <= cntInc;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (processed_dat_valid && !acceptWord) begin
            seqErr_q    <= 1'b1;
            wordsRcvd_q <= '0;
            state_q     <= EMPTY;
          end else if (prepro_finished) begin
            if (cntInc == TOTAL_W) begin
              wordsRcvd_q <= cntInc;
              frameDone_q <= 1'b1;
              state_q     <= READY;
            end else begin
              seqErr_q    <= 1'b1;
              wordsRcvd_q <= '0;
              state_q     <= EMPTY;
            end
          end else begin
            wordsRcvd_q <= cntInc;
          end
        end
        READY: begin
          if (buf_release) begin
            if (acceptWord) begin
              wordsRcvd_q <= {{ADDR_W{1'b0}}, 1'b1};
              state_q     <= FILL;
            end else begin
              if (processed_dat_valid) begin
                seqErr_q <= 1'b1;
              end
              wordsRcvd_q <= '0;
              state_q     <= EMPTY;
            end
          end else if (processed_dat_valid) begin
            seqErr_q <= 1'b1;
          end
          if (prepro_finished) begin
            seqErr_q <= 1'b1;
          end
        end
        default: begin
          wordsRcvd_q <= '0;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  // Tracks whether last cycle's read address was inside the frame; also forces
  // rd_data to zero out of reset while the RAM output is still undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdInRange_q <= 1'b0;
    end else begin
      rdInRange_q <= ({1'b0, rd_addr} < TOTAL_W);
    end
  end

  prepro_frame_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .wrEn_i   (acceptWord),
    .wrAddr_i (processed_dat_addr),
    .wrData_i (processed_dat_in),
    .rdAddr_i (rd_addr),
    .rdData_o (ramData)
  );

  assign rd_data    = rdInRange_q ? ramData : '0;
  assign buf_ready  = (state_q == READY);
  assign frame_done = frameDone_q;
  assign words_rcvd = wordsRcvd_q;
  assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_prepro_frame_receiver.sv
// Directed bench for prepro_frame_receiver: default depth instance plus a
// num_of_reg=2 instance sharing the same stream.
module tb_prepro_frame_receiver;
  import prepro_frame_receiver_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int TOT = 1020;
  localparam int TOT2 = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, valid = 1'b0, finished = 1'b0, bufRelease = 1'b0, errClr = 1'b0;
  logic [AW-1:0] addr = '0, rdAddr = '0;
  logic [DW-1:0] dataIn = '0;
  logic [DW-1:0] rdData, rdData2;
  logic          bufReady, frameDone, seqErr, bufReady2, frameDone2, seqErr2;
  logic [AW:0]   wordsRcvd, wordsRcvd2;

  int nChecks = 0;
  int nFail = 0;
  logic [DW-1:0] expQ[$];

  prepro_frame_receiver dut (
    .clk(clk), .rst(rst), .processed_dat_valid(valid), .processed_dat_addr(addr),
    .processed_dat_in(dataIn), .prepro_finished(finished), .rd_addr(rdAddr),
    .rd_data(rdData), .buf_ready(bufReady), .buf_release(bufRelease),
    .frame_done(frameDone), .words_rcvd(wordsRcvd), .seq_err(seqErr), .err_clr(errClr)
  );

  prepro_frame_receiver #(.num_of_reg(2)) dut2 (
    .clk(clk), .rst(rst), .processed_dat_valid(valid), .processed_dat_addr(addr),
    .processed_dat_in(dataIn), .prepro_finished(finished), .rd_addr(rdAddr),
    .rd_data(rdData2), .buf_ready(bufReady2), .buf_release(bufRelease),
    .frame_done(frameDone2), .words_rcvd(wordsRcvd2), .seq_err(seqErr2), .err_clr(errClr)
  );

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dataOf(input int i, input int mul, input int add);
    int v;
    v = (i * mul + add) & 255;
    return v[DW-1:0];
  endfunction

  task automatic applyStimulus(input int first, input int last, input int mul, input int add);
    for (int i = first; i <= last; i++) begin
      valid = 1'b1;
      addr = i[AW-1:0];
      dataIn = dataOf(i, mul, add);
      cycle();
    end
    valid = 1'b0;
  endtask

  task automatic pulseFinished();
    finished = 1'b1;
    cycle();
    finished = 1'b0;
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    cycle();
    errClr = 1'b0;
  endtask

  // Scoreboard read: expected word queued when the address is driven,
  // popped and compared when the registered read data appears.
  task automatic readCheck(input string tag, input int a, input int exp, input bit second);
    logic [DW-1:0] e;
    logic [DW-1:0] obs;
    rdAddr = a[AW-1:0];
    expQ.push_back(exp[DW-1:0]);
    cycle();
    e = expQ.pop_front();
    obs = second ? rdData2 : rdData;
    checkOutput(tag, {24'd0, obs}, {24'd0, e});
  endtask

  task automatic checkFrame(input int mul, input int add);
    for (int i = 0; i < TOT; i++) begin
      readCheck("frame_word", i, int'(dataOf(i, mul, add)), 1'b0);
    end
  endtask

  task automatic startWithRelease(input int mul, input int add);
    bufRelease = 1'b1;
    valid = 1'b1;
    addr = '0;
    dataIn = dataOf(0, mul, add);
    cycle();
    bufRelease = 1'b0;
    valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    checkOutput("rst_buf_ready", 32'(bufReady), 0);
    checkOutput("rst_words", 32'(wordsRcvd), 0);
    checkOutput("rst_seq_err", 32'(seqErr), 0);
    checkOutput("rst_frame_done", 32'(frameDone), 0);
    readCheck("rst_rd_data", 0, 0, 1'b0);
    rst = 1'b0;
    cycle();

    // Nominal frame
    applyStimulus(0, TOT - 1, 1, 0);
    checkOutput("fill_words", 32'(wordsRcvd), TOT);
    checkOutput("fill_not_ready", 32'(bufReady), 0);
    pulseFinished();
    checkOutput("nom_frame_done", 32'(frameDone), 1);
    checkOutput("nom_buf_ready", 32'(bufReady), 1);
    checkOutput("nom_words", 32'(wordsRcvd), TOT);
    checkOutput("nom_seq_err", 32'(seqErr), 0);
    cycle();
    checkOutput("nom_done_pulse", 32'(frameDone), 0);
    readCheck("rd_last", TOT - 1, 8'hFB, 1'b0);
    readCheck("rd_oor_1020", TOT, 0, 1'b0);
    readCheck("rd_oor_1023", 1023, 0, 1'b0);

    // Overrun while READY is rejected and the buffer is untouched
    valid = 1'b1; addr = 10'd5; dataIn = 8'hAA;
    cycle();
    valid = 1'b0;
    checkOutput("ovr_seq_err", 32'(seqErr), 1);
    checkOutput("ovr_still_ready", 32'(bufReady), 1);
    readCheck("ovr_rd5", 5, 5, 1'b0);
    pulseErrClr();
    checkOutput("ovr_err_clr", 32'(seqErr), 0);

    // Release together with the first word of the next frame
    startWithRelease(1, 0);
    checkOutput("rel_fill_words", 32'(wordsRcvd), 1);
    checkOutput("rel_not_ready", 32'(bufReady), 0);
    checkOutput("rel_seq_err", 32'(seqErr), 0);
    applyStimulus(1, TOT - 1, 1, 0);
    pulseFinished();
    checkOutput("rel_frame_done", 32'(frameDone), 1);
    checkOutput("rel_ready", 32'(bufReady), 1);
    bufRelease = 1'b1;
    cycle();
    bufRelease = 1'b0;
    checkOutput("release_empty", 32'(bufReady), 0);
    checkOutput("release_words", 32'(wordsRcvd), 0);

    // Events in EMPTY
    bufRelease = 1'b1;
    cycle();
    bufRelease = 1'b0;
    checkOutput("empty_release_ignored", 32'(bufReady), 0);
    checkOutput("empty_release_err", 32'(seqErr), 0);
    valid = 1'b1; addr = 10'd7; errClr = 1'b1;
    cycle();
    valid = 1'b0; errClr = 1'b0;
    checkOutput("empty_bad_addr_set_wins", 32'(seqErr), 1);
    checkOutput("empty_bad_addr_words", 32'(wordsRcvd), 0);
    pulseErrClr();
    pulseFinished();
    checkOutput("empty_finished_err", 32'(seqErr), 1);
    checkOutput("empty_finished_done", 32'(frameDone), 0);
    pulseErrClr();

    // Out-of-order address
    applyStimulus(0, 99, 1, 0);
    checkOutput("ooo_words_before", 32'(wordsRcvd), 100);
    applyStimulus(101, 101, 1, 0);
    checkOutput("ooo_seq_err", 32'(seqErr), 1);
    checkOutput("ooo_words", 32'(wordsRcvd), 0);
    checkOutput("ooo_not_ready", 32'(bufReady), 0);
    pulseErrClr();
    checkOutput("ooo_err_clr", 32'(seqErr), 0);

    // Short frame
    applyStimulus(0, TOT - 2, 1, 0);
    pulseFinished();
    checkOutput("short_seq_err", 32'(seqErr), 1);
    checkOutput("short_no_done", 32'(frameDone), 0);
    checkOutput("short_words", 32'(wordsRcvd), 0);
    checkOutput("short_not_ready", 32'(bufReady), 0);
    pulseErrClr();

    // Long frame
    applyStimulus(0, TOT - 1, 1, 0);
    applyStimulus(TOT, TOT, 1, 0);
    checkOutput("long_seq_err", 32'(seqErr), 1);
    checkOutput("long_words", 32'(wordsRcvd), 0);
    checkOutput("long_not_ready", 32'(bufReady), 0);
    pulseErrClr();

    // Reset mid-fill with a pending error, then a fresh full frame
    applyStimulus(3, 3, 1, 0);
    applyStimulus(0, 499, 1, 8'h5A);
    checkOutput("mid_pre_err", 32'(seqErr), 1);
    checkOutput("mid_pre_words", 32'(wordsRcvd), 500);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checkOutput("mid_rst_ready", 32'(bufReady), 0);
    checkOutput("mid_rst_words", 32'(wordsRcvd), 0);
    checkOutput("mid_rst_err", 32'(seqErr), 0);
    applyStimulus(0, TOT - 1, 3, 1);
    pulseFinished();
    checkOutput("mid_ready", 32'(bufReady), 1);
    checkFrame(3, 1);

    // Back-to-back frames, each released the cycle after frame_done
    startWithRelease(5, 7);
    applyStimulus(1, TOT - 1, 5, 7);
    pulseFinished();
    checkOutput("b2b_done_b", 32'(frameDone), 1);
    startWithRelease(7, 3);
    checkOutput("b2b_words_c", 32'(wordsRcvd), 1);
    applyStimulus(1, TOT - 1, 7, 3);
    pulseFinished();
    checkOutput("b2b_done_c", 32'(frameDone), 1);
    checkOutput("b2b_seq_err", 32'(seqErr), 0);
    checkOutput("b2b_words", 32'(wordsRcvd), TOT);
    checkFrame(7, 3);

    // num_of_reg = 2 instance takes a 1023-word frame
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    applyStimulus(0, TOT2 - 1, 1, 0);
    pulseFinished();
    checkOutput("n2_frame_done", 32'(frameDone2), 1);
    checkOutput("n2_ready", 32'(bufReady2), 1);
    checkOutput("n2_words", 32'(wordsRcvd2), TOT2);
    checkOutput("n2_seq_err", 32'(seqErr2), 0);
    checkOutput("n2_default_rejects", 32'(bufReady), 0);
    readCheck("n2_rd_last", TOT2 - 1, 8'hFE, 1'b1);
    readCheck("n2_rd_1019", 1019, 8'hFB, 1'b1);
    readCheck("n2_rd_oor", 1023, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/prepro_frame_receiver.md
Name: prepro_frame_receiver

Overview:
- Receiving end of the preprocessing transmit stream: consumes `processed_dat_valid`, `processed_dat_addr`, the data word and `prepro_finished`.
- Checks the address sequence 0..TOTAL-1 and stores each word into a 1024-deep frame buffer.
- Presents a completed frame to the downstream SNN input layer through a synchronous read port, guarded by a ready/release handshake.
- Rejects short, long, out-of-order and overrun frames and flags them on a sticky error.

Parameters:
- num_of_reg, 5, preprocessing register depth; TOTAL = 1024 - num_of_reg + 1 (default 1020).
- DATA_W, 8, width of one processed data word.
- ADDR_W, 10, address width of the stream and the buffer.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- processed_dat_valid  in  1  stream word valid.
- processed_dat_addr  in  ADDR_W  stream word index.
- processed_dat_in  in  DATA_W  stream word.
- prepro_finished  in  1  one-cycle end-of-frame pulse from the transmitter.
- rd_addr  in  ADDR_W  downstream read address.
- rd_data  out  DATA_W  buffer word; registered, 1-cycle latency.
- buf_ready  out  1  complete frame held in buffer.
- buf_release  in  1  one-cycle pulse: downstream has finished with the frame.
- frame_done  out  1  one-cycle pulse on entry to READY.
- words_rcvd  out  ADDR_W+1  words accepted in the current frame.
- seq_err  out  1  sticky protocol error.
- err_clr  in  1  clears seq_err.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=EMPTY, words_rcvd=0, buf_ready=0, frame_done=0, seq_err=0, rd_data=0.
  - Buffer contents are not cleared.
  - Reset mid-frame discards the partial frame.
- States: EMPTY, FILL, READY (2-bit encoding in package). buf_ready=1 only in READY.
- Accept means: buffer[addr] <= data and words_rcvd++.
- EMPTY:
  - valid with addr==0: accept, go to FILL.
  - valid with addr!=0: seq_err<=1, word dropped, stay.
  - prepro_finished: seq_err<=1, stay.
- FILL (expected addr = words_rcvd):
  - valid with addr==expected and words_rcvd<TOTAL: accept.
  - valid with wrong addr, or words_rcvd==TOTAL (long frame): seq_err<=1, words_rcvd<=0, go to EMPTY, word dropped.
  - prepro_finished with words_rcvd==TOTAL: go to READY, frame_done=1 for that one cycle.
  - prepro_finished with words_rcvd!=TOTAL (short frame): seq_err<=1, words_rcvd<=0, go to EMPTY.
  - valid and prepro_finished in the same cycle: the word is checked and accepted first; finished is then evaluated against the incremented count.
- READY:
  - Buffer is write-protected.
  - valid (overrun): seq_err<=1, word dropped.
  - buf_release: words_rcvd<=0, go to EMPTY.
  - buf_release and valid with addr==0 in the same cycle: word accepted, words_rcvd<=1, go to FILL.
  - buf_release and valid with addr!=0 in the same cycle: seq_err<=1, go to EMPTY.
  - prepro_finished in READY: seq_err<=1.
- buf_release outside READY is ignored.
- Read port:
  - rd_data <= buffer[rd_addr] every cycle, in any state.
  - rd_addr >= TOTAL returns 0.
  - Read-during-write to the same address returns the old data.
- seq_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- Arithmetic: words_rcvd is ADDR_W+1 bits, so the value TOTAL is representable without wrap. Address compare is unsigned, full width.

Decomposition:
- Shared package holds:
  - The state localparams EMPTY=0, FILL=1, READY=2.
  - TOTAL_INPUT_NUM derived from num_of_reg.
  - DATA_W/ADDR_W defaults, shared with the preprocessing transmitter so both ends agree on TOTAL.
- One sub-module, prepro_frame_ram:
  - 2^ADDR_W x DATA_W, one write port, one registered read port, read-old-on-collision.
- Control FSM, sequence checker and read-range mux stay in prepro_frame_receiver.

Test Plan:
- Nominal frame: addr 0..1019 with data=addr[7:0], then finished → frame_done pulses once, buf_ready=1, words_rcvd=1020, seq_err=0. rd_addr=1019 gives rd_data=0xFB one cycle later; rd_addr=1020 gives 0.
- Out-of-order: send 0..99, then addr 101 → seq_err=1, state EMPTY, words_rcvd=0, buf_ready stays 0. err_clr → seq_err=0.
- Short frame: 0..1018 then finished → seq_err=1, no frame_done, EMPTY. Long frame: 0..1019, then addr 1020 before finished → seq_err=1, EMPTY.
- Overrun in READY: valid addr 5, data 0xAA → seq_err=1, rd_addr=5 still returns the original word.
- Then buf_release together with valid addr 0 → state FILL, words_rcvd=1; full frame completes normally.
- Reset mid-fill after 500 words → buf_ready=0, words_rcvd=0, seq_err=0. A following complete frame 0..1019 + finished reaches READY with all 1020 words correct.
- With num_of_reg=2 (TOTAL=1023): full frame reaches READY. With DIAG-style back-to-back frames (release the cycle after frame_done), no words are lost.
